// File: rtl/mem_common.sv
// Shared memory-request/response types used by the instruction-side memory path.
package mem_common;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } t_mem_req;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } t_mem_rsp;

endpackage

// File: rtl/icache_arb.sv
// Shares the icache request port between fetch buffer (demand) and prefetcher,
// tags requests with a slot id and routes fixed-latency responses back home.
module icache_arb
  import mem_common::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic     clk,
  input  logic     reset_n,
  input  t_mem_req fb_arb_req_nnn,
  output logic     arb_fb_rdy_nnn,
  input  t_mem_req pf_arb_req_nnn,
  output logic     arb_pf_rdy_nnn,
  input  logic     flush,
  output t_mem_req arb_ic_req_nnn,
  input  t_mem_rsp ic_arb_rsp_nnn,
  output t_mem_rsp arb_fb_rsp_nnn,
  output t_mem_rsp arb_pf_rsp_nnn,
  output logic     busy
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

  logic [NUM_SLOTS-1:0] slot_valid;
  logic [NUM_SLOTS-1:0] slot_owner;   // 0 = fetch buffer, 1 = prefetcher
  logic [NUM_SLOTS-1:0] slot_killed;
  logic [ID_W-1:0]      slot_orig_id [NUM_SLOTS];

  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic              can_accept, pf_forced, fb_grant, pf_grant, grant;
  logic [SLOT_W-1:0] alloc_idx, rsp_slot;
  logic              rsp_hit;
  logic [ID_W-1:0]   win_id;
  logic [ADDR_W-1:0] win_addr;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    can_accept = !(&slot_valid) && !flush && reset_n;
    pf_forced  = (starve_cnt == CNT_W'(STARVE_LIMIT));
    fb_grant   = can_accept && fb_arb_req_nnn.valid && !(pf_arb_req_nnn.valid && pf_forced);
    pf_grant   = can_accept && pf_arb_req_nnn.valid && (!fb_arb_req_nnn.valid || pf_forced);
    grant      = fb_grant || pf_grant;
    win_id     = pf_grant ? pf_arb_req_nnn.id   : fb_arb_req_nnn.id;
    win_addr   = pf_grant ? pf_arb_req_nnn.addr : fb_arb_req_nnn.addr;

    // Scan high to low so the lowest invalid slot is the one left standing.
    alloc_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) alloc_idx = SLOT_W'(i);
    end

    // Hold when the grant was blocked by a full table or flush.
    starve_cnt_nxt = starve_cnt;
    if (pf_grant || !pf_arb_req_nnn.valid) begin
      starve_cnt_nxt = '0;
    end else if (fb_grant && !pf_forced) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end

    // Ids beyond the slot range never match a live slot.
    rsp_slot = ic_arb_rsp_nnn.id[SLOT_W-1:0];
    rsp_hit  = ic_arb_rsp_nnn.valid && ((ic_arb_rsp_nnn.id >> SLOT_W) == '0) && slot_valid[rsp_slot];
  end

  assign arb_fb_rdy_nnn = fb_grant;
  assign arb_pf_rdy_nnn = pf_grant;
  assign busy           = |slot_valid;

  // NOTE: sequential state is updated with non-blocking assignments only, so later
  // statements in the block still see start-of-cycle values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid  <= '0;
      slot_owner  <= '0;
      slot_killed <= '0;
      starve_cnt  <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      if (rsp_hit) slot_valid[rsp_slot] <= 1'b0;
      if (grant) begin
        slot_valid[alloc_idx]  <= 1'b1;
        slot_owner[alloc_idx]  <= pf_grant;
        slot_killed[alloc_idx] <= 1'b0;
      end
      // No grant happens while flush is high, so only live slots need marking.
      if (flush) slot_killed <= slot_killed | slot_valid;
    end
  end

  // NOTE: payload storage is left unreset; it is only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (grant) slot_orig_id[alloc_idx] <= win_id;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arb_ic_req_nnn <= '0;
      arb_fb_rsp_nnn <= '0;
      arb_pf_rsp_nnn <= '0;
    end else begin
      arb_ic_req_nnn <= '0;
      arb_fb_rsp_nnn <= '0;
      arb_pf_rsp_nnn <= '0;
      if (grant) begin
        arb_ic_req_nnn.valid <= 1'b1;
        arb_ic_req_nnn.id    <= ID_W'(alloc_idx);
        arb_ic_req_nnn.addr  <= win_addr;
      end
      if (rsp_hit && !slot_killed[rsp_slot]) begin
        if (slot_owner[rsp_slot]) begin
          arb_pf_rsp_nnn <= '{valid: 1'b1, id: slot_orig_id[rsp_slot], data: ic_arb_rsp_nnn.data};
        end else begin
          arb_fb_rsp_nnn <= '{valid: 1'b1, id: slot_orig_id[rsp_slot], data: ic_arb_rsp_nnn.data};
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Responses still in flight across a reset are expected to miss for a few cycles.
  logic [3:0] assert_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) assert_mask <= 4'd8;
    else if (assert_mask != 4'd0) assert_mask <= assert_mask - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset_n && assert_mask == 4'd0 && ic_arb_rsp_nnn.valid) assert (rsp_hit);
  end
`endif

endmodule

// File: tb/tb_icache_arb.sv
// Self-checking bench for icache_arb: fixed-latency icache model, scoreboard of
// expected icache requests and routed responses, plus directed timing checks.
module tb_icache_arb;
  import mem_common::*;

  localparam int NUM_SLOTS    = 4;
  localparam int STARVE_LIMIT = 3;

  logic     clk = 1'b0;
  logic     reset_n;
  logic     flush;
  t_mem_req fb_req, pf_req, ic_req;
  t_mem_rsp ic_rsp, fb_rsp, pf_rsp;
  logic     fb_rdy, pf_rdy, busy;

  always #5 clk = ~clk;

  icache_arb #(.NUM_SLOTS(NUM_SLOTS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fb_arb_req_nnn (fb_req),
    .arb_fb_rdy_nnn (fb_rdy),
    .pf_arb_req_nnn (pf_req),
    .arb_pf_rdy_nnn (pf_rdy),
    .flush          (flush),
    .arb_ic_req_nnn (ic_req),
    .ic_arb_rsp_nnn (ic_rsp),
    .arb_fb_rsp_nnn (fb_rsp),
    .arb_pf_rsp_nnn (pf_rsp),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] irom_word(input logic [31:0] idx);
    return 32'h1000_0000 + idx * 32'h0000_0101;
  endfunction

  // ---------------- icache model: fixed latency, in-order ----------------
  typedef struct {
    int          due;
    logic [3:0]  id;
    logic [31:0] addr;
  } t_pend;

  t_pend pend[$];
  int    lat = 1;
  int    cyc = 0;

  initial begin
    ic_rsp = '0;
    forever begin
      @(negedge clk);
      cyc++;
      ic_rsp = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        t_pend p;
        p = pend.pop_front();
        ic_rsp = '{valid: 1'b1, id: p.id, data: irom_word(p.addr >> 2)};
      end
      if (ic_req.valid) pend.push_back('{cyc + lat, ic_req.id, ic_req.addr});
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0]  id;
    logic [31:0] val;
  } t_exp;

  t_exp                 exp_ic[$], exp_fb[$], exp_pf[$];
  logic [NUM_SLOTS-1:0] occ = '0;

  task automatic expect_grant(input t_mem_req r, input logic is_pf);
    int slot;
    slot = 0;
    check("alloc_has_free_slot", &occ, 1'b0);
    for (int i = NUM_SLOTS - 1; i >= 0; i--) if (!occ[i]) slot = i;
    occ[slot] = 1'b1;
    exp_ic.push_back('{4'(slot), r.addr});
    if (is_pf) exp_pf.push_back('{r.id, irom_word(r.addr >> 2)});
    else       exp_fb.push_back('{r.id, irom_word(r.addr >> 2)});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        exp_ic.delete();
        exp_fb.delete();
        exp_pf.delete();
        occ = '0;
      end else begin
        if (ic_req.valid) begin
          if (exp_ic.size() == 0) check("ic_req_unexpected", ic_req.valid, 1'b0);
          else begin
            t_exp e;
            e = exp_ic.pop_front();
            check("ic_req_slot", ic_req.id, e.id);
            check("ic_req_addr", ic_req.addr, e.val);
          end
        end
        if (fb_rsp.valid) begin
          if (exp_fb.size() == 0) check("fb_rsp_unexpected", fb_rsp.valid, 1'b0);
          else begin
            t_exp e;
            e = exp_fb.pop_front();
            check("fb_rsp_id", fb_rsp.id, e.id);
            check("fb_rsp_data", fb_rsp.data, e.val);
          end
        end
        if (pf_rsp.valid) begin
          if (exp_pf.size() == 0) check("pf_rsp_unexpected", pf_rsp.valid, 1'b0);
          else begin
            t_exp e;
            e = exp_pf.pop_front();
            check("pf_rsp_id", pf_rsp.id, e.id);
            check("pf_rsp_data", pf_rsp.data, e.val);
          end
        end
        check("one_rdy_max", fb_rdy & pf_rdy, 1'b0);
        if (fb_req.valid && fb_rdy) expect_grant(fb_req, 1'b0);
        if (pf_req.valid && pf_rdy) expect_grant(pf_req, 1'b1);
        if (flush) begin
          exp_fb.delete();
          exp_pf.delete();
        end
        if (ic_rsp.valid && ic_rsp.id < NUM_SLOTS) occ[ic_rsp.id[1:0]] = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] fb_id, pf_id;
    int         acc, stall, rsp_cnt;
    logic       got;

    fb_req  = '0;
    pf_req  = '0;
    flush   = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_fb_rdy", fb_rdy, 1'b0);
    check("rst_ic_req", ic_req, '0);
    check("rst_fb_rsp", fb_rsp, '0);
    check("rst_pf_rsp", pf_rsp, '0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk) reset_n = 1'b1;

    // Single demand request, latency 1
    @(negedge clk);
    fb_req = '{valid: 1'b1, id: 4'd5, addr: 32'h40};
    #2 check("t1_rdy", fb_rdy, 1'b1);
    @(negedge clk);
    fb_req = '0;
    #2;
    check("t1_ic_valid", ic_req.valid, 1'b1);
    check("t1_ic_id", ic_req.id, 4'd0);
    check("t1_busy_t1", busy, 1'b1);
    @(negedge clk);
    #2;
    check("t1_busy_t2", busy, 1'b1);
    check("t1_no_rsp_t2", fb_rsp.valid, 1'b0);
    @(negedge clk);
    #2;
    check("t1_rsp_valid", fb_rsp.valid, 1'b1);
    check("t1_rsp_id", fb_rsp.id, 4'd5);
    check("t1_rsp_data", fb_rsp.data, irom_word(32'd16));
    check("t1_busy_t3", busy, 1'b0);

    // Both requesters valid continuously: fb, fb, fb, pf, ...
    fb_id = 4'd0;
    pf_id = 4'd8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fb_req = '{valid: 1'b1, id: fb_id, addr: 32'h100 + 32'(fb_id) * 4};
      pf_req = '{valid: 1'b1, id: pf_id, addr: 32'h800 + 32'(pf_id) * 4};
      #2;
      check("t2_fb_rdy", fb_rdy, (i % 4) != 3);
      check("t2_pf_rdy", pf_rdy, (i % 4) == 3);
      if (fb_rdy) fb_id++;
      if (pf_rdy) pf_id++;
    end
    @(negedge clk);
    fb_req = '0;
    pf_req = '0;
    repeat (5) @(negedge clk);

    // Five back-to-back demands, latency 4, four slots
    lat   = 4;
    acc   = 0;
    stall = 0;
    for (int c = 0; c < 12 && acc < 5; c++) begin
      @(negedge clk);
      fb_req = '{valid: 1'b1, id: 4'(acc), addr: 32'h200 + 32'(acc) * 4};
      #2;
      if (c == 4) check("t3_full_busy", busy, 1'b1);
      if (c == 5) begin
        check("t3_free_rsp_arrives", ic_rsp.valid, 1'b1);
        check("t3_no_accept_on_free_cycle", fb_rdy, 1'b0);
      end
      if (fb_rdy) acc++;
      else stall++;
    end
    @(negedge clk);
    fb_req = '0;
    #2;
    check("t3_accepted", acc, 5);
    check("t3_stall_cycles", stall, 2);
    check("t3_reuse_valid", ic_req.valid, 1'b1);
    check("t3_reuse_slot0", ic_req.id, 4'd0);
    repeat (8) @(negedge clk);

    // Flush with three outstanding
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      fb_req = '{valid: 1'b1, id: 4'(10 + k), addr: 32'h300 + 32'(k) * 4};
      #2 check("t4_pre_rdy", fb_rdy, 1'b1);
    end
    @(negedge clk);
    fb_req = '{valid: 1'b1, id: 4'd13, addr: 32'h30c};
    flush  = 1'b1;
    #2 check("t4_flush_no_accept", fb_rdy, 1'b0);
    @(negedge clk);
    flush   = 1'b0;
    fb_req  = '0;
    rsp_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      #2;
      check("t4_no_fb_rsp", fb_rsp.valid, 1'b0);
      check("t4_no_pf_rsp", pf_rsp.valid, 1'b0);
      if (ic_rsp.valid) rsp_cnt++;
      @(negedge clk);
    end
    #2;
    check("t4_ic_rsp_count", rsp_cnt, 3);
    check("t4_slots_free", busy, 1'b0);
    @(negedge clk);
    fb_req = '{valid: 1'b1, id: 4'd7, addr: 32'h44};
    #2 check("t4_post_rdy", fb_rdy, 1'b1);
    @(negedge clk);
    fb_req = '0;
    got    = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #2 if (fb_rsp.valid) got = 1'b1;
      @(negedge clk);
    end
    check("t4_post_rsp_seen", got, 1'b1);

    // Reset mid-stream with two outstanding
    fb_req = '{valid: 1'b1, id: 4'd1, addr: 32'h500};
    #2 check("t5_rdy_a", fb_rdy, 1'b1);
    @(negedge clk);
    fb_req = '{valid: 1'b1, id: 4'd2, addr: 32'h504};
    #2 check("t5_rdy_b", fb_rdy, 1'b1);
    @(negedge clk);
    fb_req = '{valid: 1'b1, id: 4'd3, addr: 32'h508};
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_fb_rdy", fb_rdy, 1'b0);
    check("t5_rst_pf_rdy", pf_rdy, 1'b0);
    check("t5_rst_ic_req", ic_req, '0);
    check("t5_rst_fb_rsp", fb_rsp, '0);
    check("t5_rst_pf_rsp", pf_rsp, '0);
    check("t5_rst_busy", busy, 1'b0);
    fb_req = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #2;
      check("t5_stale_dropped", fb_rsp.valid, 1'b0);
    end
    @(negedge clk);
    fb_req = '{valid: 1'b1, id: 4'd9, addr: 32'h600};
    #2 check("t5_post_rdy", fb_rdy, 1'b1);
    @(negedge clk);
    fb_req = '0;
    #2;
    check("t5_post_ic_valid", ic_req.valid, 1'b1);
    check("t5_post_slot0", ic_req.id, 4'd0);
    repeat (8) @(negedge clk);
    #2;
    check("t5_end_idle", busy, 1'b0);
    check("end_scoreboard_empty", exp_fb.size() + exp_pf.size() + exp_ic.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
